// File: rtl/main_mem_responder.sv
// Memory-side responder: 64-byte block reads, 32-bit word writes, fixed-latency ready pulse.
// Optional MEM_RESP_ERR_EN adds mem_err for busy/collision requests and out-of-range addresses.
module main_mem_responder #(
    parameter int unsigned MEM_WORDS     = 4096,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    input  logic         mem_read_req,
    input  logic         mem_write_req,
    output logic [511:0] mem_block_out,
    output logic         mem_ready,
`ifdef MEM_RESP_ERR_EN
    output logic         mem_err,
`endif
    output logic         mem_busy
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESPOND} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [511:0]    block_q;
    logic            ready_q;
    logic [31:0]     mem_q [MEM_WORDS];
    logic            commit_d;
    logic            wr_ok;
    logic            unused_addr;

    assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

`ifdef MEM_RESP_ERR_EN
    logic oor_q;
    logic err_q;
    logic oor_in;

    // Out-of-range is judged on the unwrapped word index.
    assign oor_in  = |mem_addr[31:AW+2];
    assign wr_ok   = !oor_q;
    assign mem_err = rst_n & (err_q
                   | ((mem_read_req | mem_write_req) & (state_q != IDLE))
                   | (mem_read_req & mem_write_req));
`else
    assign wr_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            block_q <= '0;
            ready_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_read_req) begin
                        idx_q   <= {mem_addr[AW+1:6], 4'b0000};
                        cnt_q   <= CW'(READ_LATENCY - 1);
                        state_q <= READ_WAIT;
`ifdef MEM_RESP_ERR_EN
                        oor_q   <= oor_in;
`endif
                    end else if (mem_write_req) begin
                        idx_q   <= mem_addr[AW+1:2];
                        wdata_q <= mem_wdata;
                        cnt_q   <= CW'(WRITE_LATENCY - 1);
                        state_q <= WRITE_WAIT;
`ifdef MEM_RESP_ERR_EN
                        oor_q   <= oor_in;
`endif
                    end
                end
                READ_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESPOND;
                        ready_q <= 1'b1;
                        for (int unsigned k = 0; k < 16; k++)
                            block_q[32*k +: 32] <= mem_q[idx_q + AW'(k)];
`ifdef MEM_RESP_ERR_EN
                        err_q   <= oor_q;
                        if (oor_q) block_q <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WRITE_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESPOND;
                        ready_q <= 1'b1;
`ifdef MEM_RESP_ERR_EN
                        err_q   <= oor_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Commit happens on the WRITE_WAIT -> RESPOND edge; a reset on that edge discards it.
    assign commit_d = rst_n && (state_q == WRITE_WAIT) && (cnt_q == '0) && wr_ok;

    always_ff @(posedge clk) begin
        if (commit_d) mem_q[idx_q] <= wdata_q;
    end

    assign mem_block_out = block_q;
    assign mem_ready     = ready_q;
    assign mem_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: timing/array reference model plus directed literal checks.
module tb_main_mem_responder;
    localparam int unsigned MW = 4096;
    localparam int unsigned RL = 4;
    localparam int unsigned WL = 2;
`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
    logic err;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  mem_wdata = '0;
    logic         mem_read_req = 1'b0;
    logic         mem_write_req = 1'b0;
    logic [511:0] blk;
    logic         rdy;
    logic         busy;

    always #5 clk = ~clk;

    main_mem_responder #(
        .MEM_WORDS(MW),
        .READ_LATENCY(RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read_req(mem_read_req),
        .mem_write_req(mem_write_req),
        .mem_block_out(blk),
        .mem_ready(rdy),
`ifdef MEM_RESP_ERR_EN
        .mem_err(err),
`endif
        .mem_busy(busy)
    );

    int checks = 0;
    int passes = 0;

    function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: storage array, one outstanding transaction described by
    // its acceptance edge and completion edge (acceptance + latency).
    logic [31:0]  mm [MW];
    int           n = 0;
    bit           act = 1'b0;
    bit           a_rd, a_oor;
    int           a_done;
    logic [31:0]  a_addr, a_data;
    logic [511:0] e_blk = '0;
    int           last_rdy_n = -1;
    int           rdy_cnt = 0;

    function automatic int unsigned widx(logic [31:0] a);
        return a[31:2] % MW;
    endfunction

    function automatic logic [511:0] read_block(logic [31:0] a, bit oor);
        logic [511:0] b = '0;
        int unsigned  base;
        if (oor) return '0;
        base = ((a[31:2] / 16) * 16) % MW;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = mm[(base + k) % MW];
        return b;
    endfunction

    always @(posedge clk) begin
        bit e_rdy, e_busy, free;
        n++;
        e_rdy = 1'b0;
        if (!rst_n) begin
            act   = 1'b0;
            e_blk = '0;
        end else begin
            free = !(act && n <= a_done + 1);
            if (act && n == a_done) begin
                e_rdy = 1'b1;
                if (a_rd) e_blk = read_block(a_addr, a_oor);
                else if (!a_oor) mm[widx(a_addr)] = a_data;
            end
            if (free && (mem_read_req || mem_write_req)) begin
                act    = 1'b1;
                a_rd   = mem_read_req;
                a_addr = mem_addr;
                a_data = mem_wdata;
                a_done = n + (mem_read_req ? RL : WL);
                a_oor  = ERR_EN && (mem_addr[31:2] >= MW);
            end
        end
        e_busy = act && n <= a_done;
        #2;
        chk("ready", 512'(rdy), 512'(e_rdy));
        chk("busy", 512'(busy), 512'(e_busy));
        chk("block", blk, e_blk);
        if (rdy) begin
            last_rdy_n = n;
            rdy_cnt++;
        end
    end

`ifdef MEM_RESP_ERR_EN
    always @(negedge clk) begin
        bit e_err;
        #4;
        e_err = rst_n && ((act && n == a_done && a_oor)
              || ((mem_read_req || mem_write_req) && act && n <= a_done)
              || (mem_read_req && mem_write_req));
        chk("err", 512'(err), 512'(e_err));
    end
`endif

    task automatic send(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int req_n);
        @(negedge clk);
        mem_read_req = r; mem_write_req = w; mem_addr = a; mem_wdata = d;
        @(posedge clk);
        #1 req_n = n;
        @(negedge clk);
        mem_read_req = 1'b0; mem_write_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk({"idle_", tag}, 512'(busy), 512'(0));
    endtask

    initial begin
        int rq, c0;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        chk("rst_ready", 512'(rdy), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_block", blk, '0);
        rst_n = 1'b1;

        for (int w = 0; w < 128; w++) begin
            send(1'b0, 1'b1, 32'(w * 4), 32'h100 + 32'(w), rq);
            wait_idle("preload");
        end

        send(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, rq);
        wait_idle("wr44");
        chk("wr_latency", 512'(last_rdy_n - rq), 512'(WL));
        send(1'b1, 1'b0, 32'h40, '0, rq);
        wait_idle("rd40");
        chk("rd_latency", 512'(last_rdy_n - rq), 512'(RL));
        chk("rd40_w1", 512'(blk[63:32]), 512'(32'hDEADBEEF));
        chk("rd40_w0", 512'(blk[31:0]), 512'(32'h110));
        chk("rd40_w2", 512'(blk[95:64]), 512'(32'h112));

        send(1'b1, 1'b0, 32'h27, '0, rq);
        wait_idle("rd27");
        for (int k = 0; k < 16; k++)
            chk("rd27_word", 512'(blk[32*k +: 32]), 512'(32'h100 + 32'(k)));

        c0 = rdy_cnt;
        send(1'b1, 1'b1, 32'h80, 32'hBAD0BAD0, rq);
        wait_idle("both");
        chk("both_pulses", 512'(rdy_cnt - c0), 512'(1));
        send(1'b1, 1'b0, 32'h80, '0, rq);
        wait_idle("rd80");
        chk("rd80_w0", 512'(blk[31:0]), 512'(32'h120));

        c0 = rdy_cnt;
        send(1'b1, 1'b0, 32'h0, '0, rq);
        send(1'b0, 1'b1, 32'h0, 32'h55555555, rq);
        wait_idle("busywr");
        chk("busy_pulses", 512'(rdy_cnt - c0), 512'(1));
        send(1'b1, 1'b0, 32'h0, '0, rq);
        wait_idle("rd0");
        chk("rd0_w0", 512'(blk[31:0]), 512'(32'h100));

        c0 = rdy_cnt;
        send(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, rq);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid_busy", 512'(busy), 512'(0));
        repeat (4) @(negedge clk);
        chk("rstmid_pulses", 512'(rdy_cnt - c0), 512'(0));
        send(1'b1, 1'b0, 32'h100, '0, rq);
        wait_idle("rd100");
        chk("rd100_w0", 512'(blk[31:0]), 512'(32'h140));

        send(1'b1, 1'b0, 32'h4000, '0, rq);
        wait_idle("wrap");
        chk("wrap_w0", 512'(blk[31:0]), 512'(ERR_EN ? 32'h0 : 32'h100));
        chk("wrap_w15", 512'(blk[511:480]), 512'(ERR_EN ? 32'h0 : 32'h10F));

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = $urandom;
            a[13:9] = '0;
            if (ERR_EN) a[31:14] = '0;
            mem_addr      = a;
            mem_wdata     = $urandom;
            mem_read_req  = ($urandom_range(0, 5) == 0);
            mem_write_req = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        mem_read_req = 1'b0; mem_write_req = 1'b0;
        wait_idle("random");

        for (int b = 0; b < 8; b++) begin
            send(1'b1, 1'b0, 32'(b * 64), '0, rq);
            wait_idle("sweep");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
